tdm_bram: RTL and testbench

TDM_BRAM -- requirements
Module: tdm_bram

---
 rtl/tdm_bram_pkg.sv | 27 ++
 rtl/tdm_bram_latch.sv | 31 +++
 rtl/tdm_bram.sv | 134 +++++++++++++
 tb/tb_tdm_bram.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/tdm_bram_pkg.sv
`default_nettype none
// ============================================================================
// tdm_bram_pkg : frame state encoding and default sizing constants
// Revision     : 1.0
// ============================================================================
package tdm_bram_pkg;

  localparam int c_word_size  = 16;
  localparam int c_insn_w     = 20;
  localparam int c_iaddr_w    = 10;
  localparam int c_daddr_w    = 5;
  localparam int c_num_iports = 2;
  localparam int c_dmem_base  = 2;

  // IRD slots are contiguous so the active port is (state - S_IRD0).
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_IRD0 = 3'd1,
    S_IRD1 = 3'd2,
    S_IRD2 = 3'd3,
    S_IRD3 = 3'd4,
    S_DRD  = 3'd5,
    S_WB   = 3'd6
  } state_t;

endpackage
`default_nettype wire

// File: rtl/tdm_bram_latch.sv
`default_nettype none
// ============================================================================
// tdm_bram_latch : per-port output hold register with fresh-data bypass
// Revision       : 1.0
// ============================================================================
module tdm_bram_latch
  import tdm_bram_pkg::*;
#(
  parameter int WIDTH = c_insn_w
) (
  input  logic             idclk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_rdata,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_hold;

  always_ff @(posedge idclk or posedge rst) begin
    if (rst) begin
      r_hold <= '0;
    end else if (i_load) begin
      r_hold <= i_rdata;
    end
  end

  assign o_q = i_load ? i_rdata : r_hold;

endmodule
`default_nettype wire

// File: rtl/tdm_bram.sv
`default_nettype none
// ============================================================================
// tdm_bram : time-multiplexed instruction/data block-RAM access sequencer
// Revision : 1.0
// ============================================================================
module tdm_bram
  import tdm_bram_pkg::*;
#(
  parameter int WORD_SIZE  = c_word_size,
  parameter int INSN_W     = c_insn_w,
  parameter int IADDR_W    = c_iaddr_w,
  parameter int DADDR_W    = c_daddr_w,
  parameter int NUM_IPORTS = c_num_iports,
  parameter int DMEM_BASE  = c_dmem_base
) (
  input  logic                          idclk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [NUM_IPORTS*IADDR_W-1:0] iaddr,
  output logic [NUM_IPORTS*INSN_W-1:0]  iout,
  output logic [NUM_IPORTS-1:0]         ivalid,
  input  logic [DADDR_W-1:0]            draddr,
  input  logic [DADDR_W-1:0]            dwaddr,
  input  logic [WORD_SIZE-1:0]          din,
  input  logic                          dwe,
  output logic [WORD_SIZE-1:0]          dout,
  output logic                          dvalid,
  input  logic                          ld_we,
  input  logic [IADDR_W-1:0]            ld_addr,
  input  logic [INSN_W-1:0]             ld_data,
  output logic                          busy,
  output logic                          ld_err
);

  localparam int                 c_idepth   = 2**IADDR_W;
  localparam int                 c_ddepth   = 2**DADDR_W;
  localparam logic [DADDR_W-1:0] c_dbase    = DADDR_W'(DMEM_BASE);
  localparam logic [2:0]         c_last_ird = 3'(int'(S_IRD0) + NUM_IPORTS - 1);

  state_t                 r_state;
  logic [INSN_W-1:0]      r_imem [c_idepth];
  logic [WORD_SIZE-1:0]   r_dmem [DMEM_BASE:c_ddepth-1];
  logic [INSN_W-1:0]      r_irdata;
  logic [WORD_SIZE-1:0]   r_drdata;
  logic [NUM_IPORTS-1:0]  r_ivalid;
  logic                   r_dvalid;
  logic                   r_dhave;
  logic [NUM_IPORTS-1:0]  w_rd_sel;
  logic [IADDR_W-1:0]     w_rd_addr;
  logic                   w_ld_ok;
  logic                   w_dwr_ok;

  always_comb begin
    w_rd_sel  = '0;
    w_rd_addr = '0;
    for (int k = 0; k < NUM_IPORTS; k++) begin
      if (r_state == state_t'(3'(int'(S_IRD0) + k))) begin
        w_rd_sel[k] = 1'b1;
        w_rd_addr   = iaddr[k*IADDR_W +: IADDR_W];
      end
    end
  end

  assign busy     = (r_state != S_IDLE);
  assign w_ld_ok  = ld_we && !busy && !start && !rst;
  assign ld_err   = ld_we && (busy || start) && !rst;
  assign w_dwr_ok = (r_state == S_WB) && dwe && (dwaddr >= c_dbase);

  always_ff @(posedge idclk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_ivalid <= '0;
      r_dvalid <= 1'b0;
      r_dhave  <= 1'b0;
    end else begin
      r_ivalid <= w_rd_sel;
      r_dvalid <= (r_state == S_DRD);
      if (r_state == S_DRD) begin
        r_dhave <= (draddr >= c_dbase);
      end
      case (r_state)
        S_IDLE:  if (start) r_state <= S_IRD0;
        S_DRD:   r_state <= S_WB;
        S_WB:    r_state <= start ? S_IRD0 : S_IDLE;
        default: begin
          if (r_state < c_last_ird) begin
            r_state <= state_t'(r_state + 3'd1);
          end else if (r_state == c_last_ird) begin
            r_state <= S_DRD;
          end else begin
            r_state <= S_IDLE;
          end
        end
      endcase
    end
  end

  // Memories carry no reset so they map onto block RAM; reset is masked downstream.
  always_ff @(posedge idclk) begin
    if (w_ld_ok) begin
      r_imem[ld_addr] <= ld_data;
    end
    if (|w_rd_sel) begin
      r_irdata <= r_imem[w_rd_addr];
    end
  end

  always_ff @(posedge idclk) begin
    if (w_dwr_ok) begin
      r_dmem[dwaddr] <= din;
    end
    if (r_state == S_DRD) begin
      r_drdata <= r_dmem[draddr];
    end
  end

  assign ivalid = r_ivalid;
  assign dvalid = r_dvalid;
  assign dout   = r_dhave ? r_drdata : '0;

  for (genvar k = 0; k < NUM_IPORTS; k++) begin : g_port
    tdm_bram_latch #(
      .WIDTH(INSN_W)
    ) u_latch (
      .idclk  (idclk),
      .rst    (rst),
      .i_load (r_ivalid[k]),
      .i_rdata(r_irdata),
      .o_q    (iout[k*INSN_W +: INSN_W])
    );
  end

endmodule
`default_nettype wire

// File: tb/tb_tdm_bram.sv
`default_nettype none
// ============================================================================
// tb_tdm_bram : scoreboard bench for tdm_bram frame sequencing and memories
// Revision    : 1.0
// ============================================================================
module tb_tdm_bram;

  localparam int WS  = 16;
  localparam int IW  = 20;
  localparam int IAW = 10;
  localparam int DAW = 5;
  localparam int NP  = 2;
  localparam int DB  = 2;

  logic              idclk = 1'b0;
  logic              rst;
  logic              start;
  logic [NP*IAW-1:0] iaddr;
  logic [NP*IW-1:0]  iout;
  logic [NP-1:0]     ivalid;
  logic [DAW-1:0]    draddr;
  logic [DAW-1:0]    dwaddr;
  logic [WS-1:0]     din;
  logic              dwe;
  logic [WS-1:0]     dout;
  logic              dvalid;
  logic              ld_we;
  logic [IAW-1:0]    ld_addr;
  logic [IW-1:0]     ld_data;
  logic              busy;
  logic              ld_err;

  tdm_bram #(
    .WORD_SIZE(WS), .INSN_W(IW), .IADDR_W(IAW), .DADDR_W(DAW),
    .NUM_IPORTS(NP), .DMEM_BASE(DB)
  ) dut (
    .idclk(idclk), .rst(rst), .start(start), .iaddr(iaddr), .iout(iout),
    .ivalid(ivalid), .draddr(draddr), .dwaddr(dwaddr), .din(din), .dwe(dwe),
    .dout(dout), .dvalid(dvalid), .ld_we(ld_we), .ld_addr(ld_addr),
    .ld_data(ld_data), .busy(busy), .ld_err(ld_err)
  );

  always #5 idclk = ~idclk;

  // port == NP tags a data-read expectation
  typedef struct {
    int          port;
    logic [31:0] val;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  int          n_checks = 0;
  int          n_pass   = 0;
  int          busy_cnt = 0;
  int          cyc      = 0;
  logic [IW-1:0] m_imem [int];
  logic [WS-1:0] m_dmem [int];
  logic [IW-1:0] hold_i [NP];
  logic [WS-1:0] hold_d;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge idclk);
    #1;
  endtask

  always @(posedge idclk) cyc++;

  always @(negedge idclk) begin
    if (!rst) begin
      if (busy) busy_cnt++;
      for (int k = 0; k < NP; k++) begin
        if (ivalid[k]) begin
          if (sb.size() == 0) begin
            check($sformatf("sb_underflow_i%0d", k), 32'(sb.size()), 32'd1);
          end else begin
            e = sb.pop_front();
            check($sformatf("ivalid_port%0d", k), 32'(e.port), 32'(k));
            check($sformatf("iout%0d_fresh", k), 32'(iout[k*IW +: IW]), e.val);
            hold_i[k] = e.val[IW-1:0];
          end
        end else begin
          check($sformatf("iout%0d_hold", k), 32'(iout[k*IW +: IW]), 32'(hold_i[k]));
        end
      end
      if (dvalid) begin
        if (sb.size() == 0) begin
          check("sb_underflow_d", 32'(sb.size()), 32'd1);
        end else begin
          e = sb.pop_front();
          check("dvalid_slot", 32'(e.port), 32'(NP));
          check("dout_fresh", 32'(dout), e.val);
          hold_d = e.val[WS-1:0];
        end
      end else begin
        check("dout_hold", 32'(dout), 32'(hold_d));
      end
    end
  end

  task automatic load(input logic [IAW-1:0] a, input logic [IW-1:0] d);
    ld_we = 1'b1; ld_addr = a; ld_data = d;
    #1 check("ld_err_idle", 32'(ld_err), 32'd0);
    tick();
    ld_we = 1'b0;
    m_imem[int'(a)] = d;
  endtask

  // Entered #1 after an edge: DUT idle (in_ird0=0) or already in IRD0 (in_ird0=1).
  task automatic frame(input logic [IAW-1:0] a0, input logic [IAW-1:0] a1,
                       input logic [DAW-1:0] dra, input logic we,
                       input logic [DAW-1:0] dwa, input logic [WS-1:0] dn,
                       input bit in_ird0, input bit chain, input bit ld_probe);
    logic [WS-1:0] dexp;
    iaddr = {a1, a0}; draddr = dra; dwe = we; dwaddr = dwa; din = dn;
    dexp = (int'(dra) < DB) ? '0 : m_dmem[int'(dra)];
    sb.push_back('{port: 0, val: 32'(m_imem[int'(a0)])});
    sb.push_back('{port: 1, val: 32'(m_imem[int'(a1)])});
    sb.push_back('{port: NP, val: 32'(dexp)});
    if (!in_ird0) begin
      start = 1'b1;
      tick();
    end
    start = chain;
    tick();
    if (ld_probe) begin
      ld_we = 1'b1; ld_addr = 10'd3; ld_data = 20'h00F0F;
      #1 check("ld_err_busy", 32'(ld_err), 32'd1);
    end
    tick();
    ld_we = 1'b0;
    tick();
    tick();
    if (we && int'(dwa) >= DB) m_dmem[int'(dwa)] = dn;
    dwe = 1'b0;
  endtask

  initial begin
    int c0;
    rst = 1'b1; start = 1'b0; iaddr = '0; draddr = '0; dwaddr = '0; din = '0;
    dwe = 1'b0; ld_we = 1'b0; ld_addr = '0; ld_data = '0;
    for (int k = 0; k < NP; k++) hold_i[k] = '0;
    hold_d = '0;
    repeat (2) @(posedge idclk);
    #1;
    check("rst_busy",   32'(busy),   32'd0);
    check("rst_ivalid", 32'(ivalid), 32'd0);
    check("rst_dvalid", 32'(dvalid), 32'd0);
    check("rst_iout",   32'(iout[IW-1:0]) | 32'(iout[2*IW-1:IW]), 32'd0);
    check("rst_dout",   32'(dout),   32'd0);
    rst = 1'b0;
    tick();

    load(10'd5, 20'hABCDE);
    load(10'd9, 20'h12345);
    load(10'd3, 20'h11111);

    frame(10'd5, 10'd9, 5'd1, 1'b1, 5'd7, 16'h5A5A, 1'b0, 1'b0, 1'b0);
    frame(10'd9, 10'd5, 5'd7, 1'b1, 5'd0, 16'hFFFF, 1'b0, 1'b0, 1'b0);
    frame(10'd5, 10'd5, 5'd0, 1'b0, 5'd0, 16'h0000, 1'b0, 1'b0, 1'b0);

    busy_cnt = 0;
    c0 = cyc;
    frame(10'd3, 10'd5, 5'd7, 1'b1, 5'd8, 16'h2222, 1'b0, 1'b1, 1'b0);
    frame(10'd9, 10'd3, 5'd8, 1'b1, 5'd9, 16'h3333, 1'b1, 1'b1, 1'b0);
    frame(10'd5, 10'd9, 5'd9, 1'b0, 5'd0, 16'h0000, 1'b1, 1'b0, 1'b0);
    check("chain_busy_cycles", 32'(busy_cnt), 32'd12);
    check("chain_elapsed", 32'(cyc - c0), 32'd13);
    check("chain_idle_after", 32'(busy), 32'd0);

    frame(10'd3, 10'd5, 5'd7, 1'b0, 5'd0, 16'h0000, 1'b0, 1'b0, 1'b1);
    load(10'd3, 20'h00F0F);
    frame(10'd3, 10'd9, 5'd7, 1'b0, 5'd0, 16'h0000, 1'b0, 1'b0, 1'b0);

    // Abort a frame in DRD with a write pending.
    iaddr = {10'd9, 10'd5}; draddr = 5'd8; dwe = 1'b1; dwaddr = 5'd8; din = 16'h1111;
    sb.push_back('{port: 0, val: 32'(m_imem[5])});
    sb.push_back('{port: 1, val: 32'(m_imem[9])});
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    @(negedge idclk);
    #1 rst = 1'b1;
    #1;
    check("abort_busy",   32'(busy),   32'd0);
    check("abort_ivalid", 32'(ivalid), 32'd0);
    check("abort_dvalid", 32'(dvalid), 32'd0);
    check("abort_iout",   32'(iout[IW-1:0]) | 32'(iout[2*IW-1:IW]), 32'd0);
    check("abort_dout",   32'(dout),   32'd0);
    for (int k = 0; k < NP; k++) hold_i[k] = '0;
    hold_d = '0;
    tick();
    rst = 1'b0;
    dwe = 1'b0;
    tick();
    frame(10'd5, 10'd9, 5'd8, 1'b0, 5'd0, 16'h0000, 1'b0, 1'b0, 1'b0);

    tick();
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
